// File: rtl/cube_merge_fill.sv
// Merges two ternary stimulus cubes position by position and resolves every '-' to a
// concrete bit, repeating the previous resolved bit and reporting per-cube status.
module cube_merge_fill #(
  parameter int   LEN_W     = 8,
  parameter logic FILL_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_sym,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_sym,
  input  logic             b_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_bit,
  output logic             o_last,
  output logic             done,
  output logic             conflict,
  output logic [LEN_W-1:0] len,
  output logic             len_ovf,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid is held with stable data until accepted. In BOTH each ready also waits for the
  // other stream's valid so the two symbols are always taken as a pair.
  typedef enum logic [2:0] {IDLE, BOTH, ONLY_A, ONLY_B, FLUSH} state_t;

  state_t           state, state_nxt;
  logic             fill;
  logic [LEN_W-1:0] cnt;
  logic             conf_acc, ovf_acc;
  logic             out_free, step, step_last, flush_done;
  logic [1:0]       sa, sb;
  logic             res_bit, res_conf;

  assign dbg_state  = state;
  assign flush_done = (state == FLUSH) && o_valid && o_ready && o_last;

  always_comb begin
    out_free  = !o_valid || o_ready;
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    step      = 1'b0;
    step_last = 1'b0;
    sa        = 2'b00;
    sb        = 2'b00;
    case (state)
      IDLE: state_nxt = BOTH;
      BOTH: begin
        a_ready = out_free && b_valid;
        b_ready = out_free && a_valid;
        step    = out_free && a_valid && b_valid;
        sa      = a_sym;
        sb      = b_sym;
        if (step) begin
          if (a_last && b_last) begin
            state_nxt = FLUSH;
            step_last = 1'b1;
          end else if (a_last) begin
            state_nxt = ONLY_B;
          end else if (b_last) begin
            state_nxt = ONLY_A;
          end
        end
      end
      ONLY_A: begin
        a_ready = out_free;
        step    = out_free && a_valid;
        sa      = a_sym;
        if (step && a_last) begin
          state_nxt = FLUSH;
          step_last = 1'b1;
        end
      end
      ONLY_B: begin
        b_ready = out_free;
        step    = out_free && b_valid;
        sb      = b_sym;
        if (step && b_last) begin
          state_nxt = FLUSH;
          step_last = 1'b1;
        end
      end
      FLUSH: if (flush_done) state_nxt = BOTH;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      step    = 1'b0;
    end
  end

  // A finished stream is fed as '-' (sa/sb default 00), so it never overrides the other side.
  always_comb begin
    res_bit  = fill;
    res_conf = 1'b0;
    case ({sa[1], sb[1]})
      2'b11: begin
        res_bit  = sa[0];
        res_conf = (sa[0] != sb[0]);
      end
      2'b10:   res_bit = sa[0];
      2'b01:   res_bit = sb[0];
      default: res_bit = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_bit    <= 1'b0;
      o_last   <= 1'b0;
      done     <= 1'b0;
      conflict <= 1'b0;
      len      <= '0;
      len_ovf  <= 1'b0;
      fill     <= FILL_INIT;
      cnt      <= '0;
      conf_acc <= 1'b0;
      ovf_acc  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (step) begin
        o_valid  <= 1'b1;
        o_bit    <= res_bit;
        o_last   <= step_last;
        fill     <= res_bit;
        conf_acc <= conf_acc | res_conf;
        if (cnt == {LEN_W{1'b1}}) ovf_acc <= 1'b1;
        else                      cnt     <= cnt + 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      // Status is latched into the output registers so it stays stable while done is high,
      // even if the next cube already takes its first step in that cycle.
      if (flush_done) begin
        done     <= 1'b1;
        len      <= cnt;
        conflict <= conf_acc;
        len_ovf  <= ovf_acc;
        cnt      <= '0;
        conf_acc <= 1'b0;
        ovf_acc  <= 1'b0;
        fill     <= FILL_INIT;
      end
    end
  end

endmodule

// File: tb/tb_cube_merge_fill.sv
// Bench for cube_merge_fill: table vectors from hand-derived cubes, a reset-mid-cube
// sequence, and random cubes checked against a string-level merge model.
module tb_cube_merge_fill;
  localparam int LEN_W = 8;
  localparam int W     = LEN_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [1:0]       a_sym = 2'b00, b_sym = 2'b00;
  logic             o_ready = 1'b0;
  logic             a_ready, b_ready, o_valid, o_bit, o_last, done, conflict, len_ovf;
  logic [LEN_W-1:0] len;
  logic [2:0]       dbg_state;

  cube_merge_fill #(.LEN_W(LEN_W), .FILL_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_sym(a_sym), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_sym(b_sym), .b_last(b_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_bit(o_bit), .o_last(o_last),
    .done(done), .conflict(conflict), .len(len), .len_ovf(len_ovf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string a;
    string b;
    string bits;
    int    conf;
    int    mode;
  } vec_t;

  logic [2:0]   a_q[$], b_q[$];
  logic [1:0]   exp_q[$];
  logic [W-1:0] res_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [1:0] enc(input byte c);
    if (c == "0") return 2'b10;
    if (c == "1") return 2'b11;
    return 2'b00;
  endfunction

  // Merge at the character level: pad the shorter cube with '-', resolve, carry fill forward.
  function automatic void ref_merge(input string a, input string b,
                                    output string bits, output int conf);
    byte fill = "0";
    int  n = (a.len() > b.len()) ? a.len() : b.len();
    bits = "";
    conf = 0;
    for (int i = 0; i < n; i++) begin
      byte ca = (i < a.len()) ? a[i] : "-";
      byte cb = (i < b.len()) ? b[i] : "-";
      byte r;
      if (ca != "-" && cb != "-") begin
        r = ca;
        if (ca != cb) conf = 1;
      end else if (ca != "-") r = ca;
      else if (cb != "-")     r = cb;
      else                    r = fill;
      fill = r;
      bits = {bits, (r == "1") ? "1" : "0"};
    end
  endfunction

  task automatic push_cube(input string a, input string b, input string bits, input int conf);
    int n = bits.len();
    for (int i = 0; i < a.len(); i++) a_q.push_back({enc(a[i]), i == a.len() - 1});
    for (int i = 0; i < b.len(); i++) b_q.push_back({enc(b[i]), i == b.len() - 1});
    for (int i = 0; i < n; i++) exp_q.push_back({bits[i] == "1", i == n - 1});
    res_q.push_back({n > 255, conf != 0, (n > 255) ? 8'd255 : 8'(n)});
  endtask

  task automatic push_model(input string a, input string b);
    string bits;
    int    conf;
    ref_merge(a, b, bits, conf);
    push_cube(a, b, bits, conf);
  endtask

  function automatic string rand_cube(input int n);
    string s = "";
    for (int i = 0; i < n; i++)
      case ($urandom_range(0, 2))
        0:       s = {s, "-"};
        1:       s = {s, "0"};
        default: s = {s, "1"};
      endcase
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: o_ready always high; 1: o_ready low on alternate cycles; 2: random valid/ready.
  task automatic run_stream(input int mode, input int max_cycles);
    int cyc = 0;
    bit a_fire = 0, b_fire = 0, prev_done = 0;
    logic [1:0]   e;
    logic [W-1:0] r;
    while (cyc < max_cycles &&
           (a_q.size() > 0 || b_q.size() > 0 || exp_q.size() > 0 || res_q.size() > 0)) begin
      @(negedge clk);
      if (a_fire) begin void'(a_q.pop_front()); a_valid = 1'b0; end
      if (b_fire) begin void'(b_q.pop_front()); b_valid = 1'b0; end
      if (!a_valid && a_q.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        a_valid = 1'b1;
        {a_sym, a_last} = a_q[0];
      end
      if (!b_valid && b_q.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        b_valid = 1'b1;
        {b_sym, b_last} = b_q[0];
      end
      case (mode)
        0:       o_ready = 1'b1;
        1:       o_ready = (cyc % 2 == 0);
        default: o_ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      if (o_valid && !o_ready) check("stall_ready", {a_ready, b_ready}, 0);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("o_bit", o_bit, e[1]);
          check("o_last", o_last, e[0]);
        end
      end
      if (done) begin
        check("done_pulse", prev_done, 0);
        if (res_q.size() == 0) check("extra_done", 1, 0);
        else begin
          r = res_q.pop_front();
          check("len", len, r[LEN_W-1:0]);
          check("conflict", conflict, r[LEN_W]);
          check("len_ovf", len_ovf, r[LEN_W+1]);
        end
      end
      prev_done = done;
      cyc++;
    end
    if (cyc >= max_cycles) begin
      check("timeout", 1, 0);
      a_q.delete(); b_q.delete(); exp_q.delete(); res_q.delete();
    end
    @(negedge clk);
    if (a_fire) a_valid = 1'b0;
    if (b_fire) b_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: "-1-",  b: "01-",  bits: "011",  conf: 0, mode: 0};
    vecs[1] = '{a: "--",   b: "-01",  bits: "001",  conf: 0, mode: 0};
    vecs[2] = '{a: "--",   b: "1-",   bits: "11",   conf: 0, mode: 0};
    vecs[3] = '{a: "0-",   b: "01",   bits: "01",   conf: 0, mode: 0};
    vecs[4] = '{a: "10",   b: "11",   bits: "10",   conf: 1, mode: 0};
    vecs[5] = '{a: "0101", b: "----", bits: "0101", conf: 0, mode: 1};

    do_reset();
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_bit", o_bit, 0);
    check("rst_o_last", o_last, 0);
    check("rst_done", done, 0);
    check("rst_conflict", conflict, 0);
    check("rst_len", len, 0);
    check("rst_len_ovf", len_ovf, 0);
    check("rst_ready", {a_ready, b_ready}, 0);

    foreach (vecs[i]) begin
      push_cube(vecs[i].a, vecs[i].b, vecs[i].bits, vecs[i].conf);
      run_stream(vecs[i].mode, 200);
    end

    // Reset lands while the second symbol of a 4-symbol cube is presented.
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_sym = enc("1"); a_last = 1'b0;
    b_valid = 1'b1; b_sym = enc("-"); b_last = 1'b0;
    o_ready = 1'b1;
    #1;
    check("mid_first_ready", {a_ready, b_ready}, 3);
    @(negedge clk);
    a_sym = enc("0");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check("mid_o_valid", o_valid, 0);
    check("mid_o_bit", o_bit, 0);
    check("mid_o_last", o_last, 0);
    check("mid_len", len, 0);
    check("mid_conflict", conflict, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("mid_no_done", done, 0);
    end
    push_cube("1", "-", "1", 0);
    run_stream(0, 200);

    for (int i = 0; i < 20; i++)
      push_model(rand_cube($urandom_range(1, 8)), rand_cube($urandom_range(1, 8)));
    run_stream(2, 5000);

    push_model(rand_cube(258), "-01");
    run_stream(0, 2000);
    push_model("1", "0");
    run_stream(2, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
